// File: rtl/pulse_sequencer_if.sv
// Pulse sequencer control/status bundle.
// master drives trigger and config, slave drives pulse outputs and status.
interface pulse_sequencer_if #(
  parameter int NCH     = 8,
  parameter int SHAPE_W = 32
);
  logic               trigger;
  logic               intaking_configs;
  logic [NCH-1:0]     channel_select;
  logic [SHAPE_W-1:0] pulse_shape;
  logic [15:0]        ch0delay;
  logic [15:0]        ch1delay;
  logic [15:0]        ch2delay;
  logic [15:0]        ch3delay;
  logic [15:0]        ch4delay;
  logic [15:0]        ch5delay;
  logic [15:0]        ch6delay;
  logic [15:0]        ch7delay;
  logic [NCH-1:0]     ch_out;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [15:0]        fire_count;

  modport master (
    output trigger, intaking_configs,
    output channel_select, pulse_shape,
    output ch0delay, ch1delay, ch2delay, ch3delay,
    output ch4delay, ch5delay, ch6delay, ch7delay,
    input  ch_out, busy, done, aborted, fire_count
  );

  modport slave (
    input  trigger, intaking_configs,
    input  channel_select, pulse_shape,
    input  ch0delay, ch1delay, ch2delay, ch3delay,
    input  ch4delay, ch5delay, ch6delay, ch7delay,
    output ch_out, busy, done, aborted, fire_count
  );
endinterface

// File: rtl/pulse_sequencer.sv
// Multi-channel delayed pulse sequencer.
// Each enabled channel shifts out a latched shape MSB-first after its own delay.
module pulse_sequencer #(
  parameter int NCH     = 8,
  parameter int SHAPE_W = 32
) (
  input logic              clk,
  input logic              rst,
  pulse_sequencer_if.slave bus
);

  localparam int IW = $clog2(SHAPE_W);
  localparam logic [IW-1:0] PTR_2ND = IW'(SHAPE_W - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [15:0]        cnt;
  logic [NCH-1:0]     sel_q;
  logic [SHAPE_W-1:0] shape_q;
  logic [15:0]        dly_in [NCH];
  logic [15:0]        dly_q  [NCH];
  logic [IW-1:0]      ptr    [NCH];
  logic [NCH-1:0]     started;
  logic [NCH-1:0]     fin;
  logic [NCH-1:0]     ch_q;
  logic               busy_q;
  logic               done_q;
  logic               abort_q;
  logic [15:0]        fc_q;
  logic               all_fin;
  logic               fire;

  assign dly_in[0] = bus.ch0delay;
  assign dly_in[1] = bus.ch1delay;
  assign dly_in[2] = bus.ch2delay;
  assign dly_in[3] = bus.ch3delay;
  assign dly_in[4] = bus.ch4delay;
  assign dly_in[5] = bus.ch5delay;
  assign dly_in[6] = bus.ch6delay;
  assign dly_in[7] = bus.ch7delay;

  assign all_fin = &(fin | ~sel_q);
  assign fire    = bus.trigger & ~bus.intaking_configs;

  assign bus.ch_out     = ch_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = abort_q;
  assign bus.fire_count = fc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      shape_q <= '0;
      started <= '0;
      fin     <= '0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      fc_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        dly_q[i] <= '0;
        ptr[i]   <= '0;
      end
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (fire) begin
            sel_q   <= bus.channel_select;
            shape_q <= bus.pulse_shape;
            cnt     <= '0;
            started <= '0;
            fin     <= '0;
            busy_q  <= 1'b1;
            for (int i = 0; i < NCH; i++) begin
              dly_q[i] <= dly_in[i];
            end
            if (bus.channel_select == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
              fc_q   <= fc_q + 16'd1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.intaking_configs) begin
            state   <= S_IDLE;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
          end else if (all_fin) begin
            state  <= S_DONE;
            ch_q   <= '0;
            done_q <= 1'b1;
            fc_q   <= fc_q + 16'd1;
          end else begin
            // saturating so a 0xFFFF delay still meets its compare
            if (cnt != 16'hFFFF) begin
              cnt <= cnt + 16'd1;
            end
            for (int i = 0; i < NCH; i++) begin
              if (!sel_q[i] || fin[i]) begin
                ch_q[i] <= 1'b0;
              end else if (started[i]) begin
                ch_q[i] <= shape_q[ptr[i]];
                ptr[i]  <= ptr[i] - 1'b1;
                if (ptr[i] == '0) begin
                  fin[i] <= 1'b1;
                end
              end else if (cnt == dly_q[i]) begin
                ch_q[i]    <= shape_q[SHAPE_W-1];
                ptr[i]     <= PTR_2ND;
                started[i] <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Scoreboard bench for pulse_sequencer.
// Stimulus queues per-edge expectations; a negedge monitor pops and compares.
module tb_pulse_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pulse_sequencer_if #(.NCH(8), .SHAPE_W(32)) bus ();

  pulse_sequencer #(.NCH(8), .SHAPE_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          e;
    logic [7:0]  ch;
    logic        bsy;
    logic        dn;
    logic        ab;
    logic [15:0] fc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          edge_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          e0;
  logic [15:0] fc_exp;
  logic [7:0][15:0] d;
  logic [7:0][15:0] d_alt;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].e <= edge_cnt) begin
      x = sb.pop_front();
      n_cmp++;
      if (x.e != edge_cnt) begin
        n_bad++;
        $display("FAIL %s: edge %0d missed, now %0d", x.tag, x.e, edge_cnt);
      end else if ({bus.ch_out, bus.busy, bus.done, bus.aborted, bus.fire_count}
                   !== {x.ch, x.bsy, x.dn, x.ab, x.fc}) begin
        n_bad++;
        $display("FAIL %s edge %0d: got ch=%h busy=%b done=%b abort=%b fc=%0d, want ch=%h busy=%b done=%b abort=%b fc=%0d",
                 x.tag, x.e, bus.ch_out, bus.busy, bus.done, bus.aborted,
                 bus.fire_count, x.ch, x.bsy, x.dn, x.ab, x.fc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e, input logic [7:0] ch, input logic bsy,
                      input logic dn, input logic ab, input logic [15:0] fc,
                      input string tag);
    exp_t x;
    x.e = e; x.ch = ch; x.bsy = bsy; x.dn = dn; x.ab = ab; x.fc = fc;
    x.tag = tag;
    sb.push_back(x);
  endtask

  function automatic int dmax(input logic [7:0] sel, input logic [7:0][15:0] dd);
    int m = 0;
    for (int i = 0; i < 8; i++)
      if (sel[i] && int'(dd[i]) > m) m = int'(dd[i]);
    return m;
  endfunction

  // ch_out[i] after edge E0+t: shape bit 31-k where k = t - delay - 1
  function automatic logic [7:0] exp_ch(input logic [7:0] sel, input logic [31:0] shp,
                                        input logic [7:0][15:0] dd, input int t);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      int k = t - int'(dd[i]) - 1;
      if (sel[i] && k >= 0 && k < 32) r[i] = shp[31-k];
    end
    return r;
  endfunction

  task automatic push_fire(input int e, input logic [7:0] sel, input logic [31:0] shp,
                           input logic [7:0][15:0] dd, input logic [15:0] fc0,
                           input int tmin, input int tmax, input string tag);
    int last = (sel == 8'h00) ? 0 : dmax(sel, dd) + 33;
    for (int t = 0; t <= last + 1 && t <= tmax; t++)
      if (t < 4 || t >= tmin)
        push(e + t, exp_ch(sel, shp, dd, t), t <= last, t == last, 1'b0,
             (t >= last) ? fc0 + 16'd1 : fc0, tag);
  endtask

  task automatic drive_cfg(input logic [7:0] sel, input logic [31:0] shp,
                           input logic [7:0][15:0] dd);
    bus.channel_select = sel;
    bus.pulse_shape    = shp;
    bus.ch0delay = dd[0]; bus.ch1delay = dd[1];
    bus.ch2delay = dd[2]; bus.ch3delay = dd[3];
    bus.ch4delay = dd[4]; bus.ch5delay = dd[5];
    bus.ch6delay = dd[6]; bus.ch7delay = dd[7];
  endtask

  task automatic fire(input logic [7:0] sel, input logic [31:0] shp,
                      input logic [7:0][15:0] dd, input logic hold);
    drive_cfg(sel, shp, dd);
    bus.trigger = 1'b1;
    step(1);
    if (!hold) bus.trigger = 1'b0;
    e0 = edge_cnt;
  endtask

  initial begin
    rst = 1'b1;
    bus.trigger = 1'b0;
    bus.intaking_configs = 1'b0;
    d = '0;
    drive_cfg(8'h00, 32'h0, d);
    fc_exp = 16'd0;
    step(2);
    push(edge_cnt, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, "reset");
    step(1);
    rst = 1'b0;

    d = '0;
    fire(8'h01, 32'h8000_0001, d, 1'b0);
    push_fire(e0, 8'h01, 32'h8000_0001, d, fc_exp, 0, 1000, "basic");
    step(34);
    fc_exp++;

    d = '0; d[0] = 16'd3; d[2] = 16'd10;
    fire(8'h05, 32'hFFFF_FFFF, d, 1'b1);
    push_fire(e0, 8'h05, 32'hFFFF_FFFF, d, fc_exp, 0, 1000, "dual_hold");
    step(44);
    bus.trigger = 1'b0;
    fc_exp++;

    d = '0; d[0] = 16'd2; d[1] = 16'd2; d[3] = 16'd5; d[2] = 16'd7; d[4] = 16'd1;
    fire(8'h0B, 32'hA5C3_0F96, d, 1'b0);
    push_fire(e0, 8'h0B, 32'hA5C3_0F96, d, fc_exp, 0, 1000, "latch");
    step(2);
    d_alt = '0;
    drive_cfg(8'hFF, 32'h0000_0000, d_alt);
    step(37);
    fc_exp++;

    fire(8'h00, 32'hFFFF_FFFF, d, 1'b0);
    push_fire(e0, 8'h00, 32'hFFFF_FFFF, d, fc_exp, 0, 1000, "sel_zero");
    step(1);
    fc_exp++;

    for (int i = 0; i < 8; i++) d[i] = 16'(i / 2);
    fire(8'hFF, 32'hF0F0_F0F0, d, 1'b0);
    push_fire(e0, 8'hFF, 32'hF0F0_F0F0, d, fc_exp, 0, 5, "pre_abort");
    step(5);
    bus.intaking_configs = 1'b1;
    bus.trigger = 1'b1;
    push(e0 + 6, 8'h00, 1'b0, 1'b0, 1'b1, fc_exp, "abort");
    push(e0 + 7, 8'h00, 1'b0, 1'b0, 1'b0, fc_exp, "abort_idle");
    push(e0 + 8, 8'h00, 1'b0, 1'b0, 1'b0, fc_exp, "abort_trig_ignored");
    step(3);
    bus.intaking_configs = 1'b0;
    bus.trigger = 1'b0;
    step(1);

    d = '0; d[7] = 16'hFFFF;
    fire(8'h80, 32'hC000_0003, d, 1'b0);
    push_fire(e0, 8'h80, 32'hC000_0003, d, fc_exp, 65528, 70000, "max_delay");
    step(65569);
    fc_exp++;

    d = '0; d[0] = 16'd4;
    fire(8'h01, 32'hFFFF_0000, d, 1'b0);
    push_fire(e0, 8'h01, 32'hFFFF_0000, d, fc_exp, 0, 10, "pre_rst");
    step(10);
    rst = 1'b1;
    bus.trigger = 1'b1;
    bus.intaking_configs = 1'b1;
    push(e0 + 11, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, "rst_mid");
    step(1);
    rst = 1'b0;
    bus.trigger = 1'b0;
    bus.intaking_configs = 1'b0;
    fc_exp = 16'd0;

    d = '0;
    fire(8'h01, 32'h8000_0001, d, 1'b0);
    push_fire(e0, 8'h01, 32'h8000_0001, d, fc_exp, 0, 1000, "after_rst");
    step(35);

    step(3);
    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: edge %0d never checked", sb[0].tag, sb[0].e);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
